// File: rtl/i2s_cfg_sequencer.sv
// Control-word owner for the I2S transceiver: applies host reconfigurations by
// draining/stopping the core, pulsing its soft reset, loading the new word and settling.
module i2s_cfg_sequencer #(
  parameter int              CW            = 15,
  parameter logic [CW-1:0]   RESET_CTRL    = '0,
  parameter int              RST_CYCLES    = 4,
  parameter int              SETTLE_CYCLES = 8,
  parameter int              TIMEOUT       = 1024,
  parameter int              SYNC_STAGES   = 2
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          cfg_req,
  input  logic [CW-1:0] cfg_word,
  input  logic          cfg_drain,
  input  logic          tx_empty,
  input  logic          if_idle,
  output logic [CW-1:0] controls,
  output logic          core_rst_n,
  output logic          stop_req,
  output logic          wr_block,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_ovr,
  output logic          cfg_err
);

  localparam int MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_LIM = (TIMEOUT > MAX_A) ? TIMEOUT : MAX_A;
  localparam int CNT_W   = $clog2(MAX_LIM) + 1;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_HALT, S_RESET, S_LOAD, S_SETTLE
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] idle_sync;
  logic                   idle_s;
  logic [CW-1:0]          shadow;
  logic                   accept;
  logic                   timeout_hit;
  logic                   timeout_evt;

  logic [CW-1:0] controls_d;
  logic          core_rst_n_d, stop_req_d, wr_block_d, cfg_busy_d;
  logic          cfg_done_d, cfg_ovr_d, cfg_err_d;

  assign idle_s      = idle_sync[SYNC_STAGES-1];
  // A request landing on the done cycle is refused so the host sees a clean handshake.
  assign accept      = (state == S_IDLE) && cfg_req && !cfg_done;
  assign timeout_hit = (cnt == TO_LAST);

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      idle_sync <= '0;
    end else begin
      idle_sync[0] <= if_idle;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        idle_sync[i] <= idle_sync[i-1];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (accept) begin
      shadow <= cfg_word;
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || (state == S_IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    timeout_evt = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (!core_rst_n)    state_nxt = S_LOAD;
          else if (cfg_drain) state_nxt = S_DRAIN;
          else                state_nxt = S_HALT;
        end
      end
      S_DRAIN: begin
        if (tx_empty) begin
          state_nxt = S_HALT;
        end else if (timeout_hit) begin
          state_nxt   = S_RESET;
          timeout_evt = 1'b1;
        end
      end
      S_HALT: begin
        if (idle_s) begin
          state_nxt = S_RESET;
        end else if (timeout_hit) begin
          state_nxt   = S_RESET;
          timeout_evt = 1'b1;
        end
      end
      S_RESET:  if (cnt == RST_LAST) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == SET_LAST) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state.
  always_comb begin
    cfg_busy_d   = (state_nxt != S_IDLE);
    wr_block_d   = (state_nxt != S_IDLE);
    stop_req_d   = (state_nxt == S_HALT);
    cfg_done_d   = (state == S_SETTLE) && (state_nxt == S_IDLE);
    cfg_ovr_d    = cfg_req && !accept;
    controls_d   = (state == S_LOAD) ? shadow : controls;
    core_rst_n_d = core_rst_n;
    if (state_nxt == S_RESET)       core_rst_n_d = 1'b0;
    else if (state_nxt == S_SETTLE) core_rst_n_d = 1'b1;
    cfg_err_d = cfg_err;
    if (accept)           cfg_err_d = 1'b0;
    else if (timeout_evt) cfg_err_d = 1'b1;
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      controls   <= RESET_CTRL;
      core_rst_n <= 1'b0;
      stop_req   <= 1'b0;
      wr_block   <= 1'b0;
      cfg_busy   <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_ovr    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      controls   <= controls_d;
      core_rst_n <= core_rst_n_d;
      stop_req   <= stop_req_d;
      wr_block   <= wr_block_d;
      cfg_busy   <= cfg_busy_d;
      cfg_done   <= cfg_done_d;
      cfg_ovr    <= cfg_ovr_d;
      cfg_err    <= cfg_err_d;
    end
  end

endmodule
